// File: rtl/mau_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mau_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one access at a time to a level-sensitive data memory,
// with registered strobes and a tagged single-cycle load response.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [2:0]        resp_rd,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

  mau_state_e        r_state;
  logic [2:0]        r_lat_cnt;
  logic [2:0]        r_tag;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data_in;
  logic              r_mem_re;
  logic              r_mem_wr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [2:0]        r_resp_rd;
  logic [15:0]       r_ld_count;
  logic [15:0]       r_st_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_lat_cnt     <= '0;
      r_tag         <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_mem_re      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_rd     <= '0;
      r_ld_count    <= '0;
      r_st_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            // Address is latched here and held for the whole strobe window.
            r_mem_address <= req_addr;
            r_tag         <= req_rd;
            if (req_we == OP_STORE) begin
              r_mem_data_in <= req_wdata;
              r_mem_wr      <= 1'b1;
              r_st_count    <= r_st_count + 16'd1;
              r_state       <= WRITE;
            end else begin
              r_mem_re   <= 1'b1;
              r_lat_cnt  <= LAT_INIT;
              r_ld_count <= r_ld_count + 16'd1;
              r_state    <= READ;
            end
          end
        end
        WRITE: begin
          r_mem_wr <= 1'b0;
          r_state  <= IDLE;
        end
        READ: begin
          if (flush) begin
            r_mem_re <= 1'b0;
            r_state  <= IDLE;
          end else if (r_lat_cnt == 3'd0) begin
            r_resp_rdata <= mem_data_out;
            r_resp_rd    <= r_tag;
            r_resp_valid <= 1'b1;
            r_mem_re     <= 1'b0;
            r_state      <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        RESP: begin
          // The pulse ends at this edge whether or not flush is high.
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;
  assign mem_re      = r_mem_re;
  assign mem_wr      = r_mem_wr;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_rd     = r_resp_rd;
  assign ld_count    = r_ld_count;
  assign st_count    = r_st_count;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the 16-bit data-memory port: the MEM-stage load/store unit of the processor.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- Drives the data memory's address, data_in, re and wr strobes, and captures mem_data_out after a fixed read latency.
- Returns load data with a tagged one-cycle response and raises busy so the pipeline stalls while an access is in flight.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory word width.
- RD_LATENCY, 1, cycles mem_re is held before mem_data_out is sampled; legal range 1..7.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  pipeline presents a request.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- req_rd  input  3  destination register tag for a load.
- flush  input  1  cancels a pending load response.
- resp_valid  output  1  load data valid; single-cycle pulse.
- resp_rdata  output  DATA_W  load data.
- resp_rd  output  3  tag echoed from the accepted load.
- busy  output  1  high whenever the state is not IDLE.
- mem_address  output  ADDR_W  to memory address.
- mem_data_in  output  DATA_W  to memory data_in.
- mem_data_out  input  DATA_W  from memory data_out.
- mem_re  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- ld_count  output  16  accepted loads, wraps 0xFFFF->0x0000.
- st_count  output  16  accepted stores, wraps 0xFFFF->0x0000.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state IDLE; every output is 0 except req_ready=1. Counters clear to 0.
- Reset mid-operation: any in-flight access is abandoned at that edge, and mem_wr/mem_re drop immediately.
- Outputs: all mem_* outputs and resp_* outputs are registered, so the level-sensitive memory never sees glitches.
- Handshake: a request is accepted when req_valid && req_ready. req_ready = (state == IDLE).
- On accept, addr, wdata, tag and we are latched. The matching counter increments at the same edge.
- State IDLE -> WRITE (store) or READ (load) on accept.
- State WRITE:
  - mem_wr=1 for exactly one cycle, with mem_address/mem_data_in = latched values.
  - Next state IDLE. No response is produced.
  - flush is ignored; an accepted store always completes.
- State READ:
  - mem_re=1 with mem_address held stable. A 3-bit counter runs from RD_LATENCY-1 down to 0.
  - At count 0, mem_data_out is captured into resp_rdata; next state RESP.
  - Store latency is 2 cycles from accept to IDLE. Load latency is RD_LATENCY+1 cycles from accept to resp_valid.
- State RESP: resp_valid=1 for one cycle with resp_rd = tag, then IDLE. resp_rdata holds its value until the next load capture.
- flush: if asserted in READ or RESP, mem_re is deasserted next edge, resp_valid is forced to 0, and the next state is IDLE. flush in IDLE has no effect.
- Invariants:
  - mem_re and mem_wr are never 1 simultaneously.
  - mem_address does not change while either strobe is high.
  - A request presented outside IDLE is not accepted and must be held by the source.
- Throughput: one access per (2 store) or (RD_LATENCY+2 load) cycles; no back-to-back overlap.

Decomposition:
- Package mau_pkg holds:
  - the state enum {IDLE, WRITE, READ, RESP};
  - OP_LOAD/OP_STORE constants;
  - the ADDR_W/DATA_W defaults.
- No sub-module is required. The latency counter and the two statistics counters stay inline.

Test Plan:
- Memory preloaded mem[0]=0x0001, mem[1]=0x0008; load addr 0x0001, tag 3, RD_LATENCY=1 -> mem_re high 1 cycle, resp_valid at accept+2 with rdata 0x0008, rd 3; ld_count=1.
- Store 0xBEEF to 0x0010, then load 0x0010 -> mem_wr exactly one cycle with address 0x0010; later resp_rdata 0xBEEF; st_count=1, ld_count=1.
- Load issued, flush asserted in READ -> resp_valid never asserts, unit back in IDLE next cycle, a following load of 0x0000 returns 0x0001.
- rst_n low during WRITE -> mem_wr low at that edge, all outputs at reset values, req_ready=1 after release.
- req_valid held continuously with alternating store/load -> req_ready low outside IDLE, no strobe overlap, busy matches the non-IDLE cycles.
- Preset ld_count to 0xFFFF via 65535 loads (or force), one more load -> ld_count reads 0x0000.
